// File: rtl/rip_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rip_fetch
// Brief    : Instruction fetch stage. Issues in-order word fetches to imem,
//            buffers the returned words and hands one per cycle to rip_decode.
// Revision : 1.0
// ============================================================================
module rip_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pc_update,
    input  logic [31:0] pc_target,
    input  logic        ex_stall,
    output logic        de_ready,
    output logic [31:0] inst_code,
    output logic [31:0] if_pc
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam int          PW      = $clog2(DEPTH);
    // Late responses can pile up across back-to-back redirects, so the
    // discard counter is a couple of bits wider than the credit counters.
    localparam int          DW      = CW + 2;
    localparam logic [CW:0] C_DEPTH = (CW + 1)'(DEPTH);
    localparam logic [31:0] C_NOP   = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_occ;
    logic [DW-1:0] r_discard;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;
    logic [31:0]   r_buf_data [DEPTH];
    logic [31:0]   r_buf_pc   [DEPTH];
    logic [31:0]   r_tag      [DEPTH];

    logic w_accept;
    logic w_push;
    logic w_drop;
    logic w_pop;
    logic w_unused_tgt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_unused_tgt = ^pc_target[1:0];

    assign imem_req  = !rst && !pc_update &&
                       (({1'b0, r_out} + {1'b0, r_occ}) < C_DEPTH);
    assign imem_addr = r_pc;
    assign w_accept  = imem_req && imem_ready;
    assign w_push    = imem_rvalid && (r_discard == '0);
    assign w_drop    = imem_rvalid && (r_discard != '0);

    assign de_ready  = (r_occ != '0) && !ex_stall && !pc_update;
    assign w_pop     = de_ready;
    assign inst_code = de_ready ? r_buf_data[r_head] : C_NOP;
    assign if_pc     = de_ready ? r_buf_pc[r_head]   : 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_out     <= '0;
            r_occ     <= '0;
            r_discard <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
        end else if (pc_update) begin
            // Everything in flight becomes stale; a response arriving now is
            // already accounted for and is simply not counted again.
            r_pc      <= {pc_target[31:2], 2'b00};
            r_out     <= '0;
            r_occ     <= '0;
            r_discard <= r_discard + DW'(r_out) - DW'(imem_rvalid);
            r_head    <= '0;
            r_tail    <= '0;
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
        end else begin
            if (w_accept) begin
                r_pc     <= r_pc + 32'd4;
                r_tag_wr <= f_inc(r_tag_wr);
            end
            if (w_push) begin
                r_tag_rd <= f_inc(r_tag_rd);
                r_tail   <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_inc(r_head);
            end
            if (w_drop) begin
                r_discard <= r_discard - DW'(1);
            end
            r_out <= r_out + CW'(w_accept) - CW'(w_push);
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_buf_data[r_tail] <= imem_rdata;
            r_buf_pc[r_tail]   <= r_tag[r_tag_rd];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rip_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rip_fetch
// Brief    : Directed bench for rip_fetch with an in-order imem model.
// Revision : 1.0
// ============================================================================
module tb_rip_fetch;

    localparam int          DEPTH    = 3;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_update;
    logic [31:0] pc_target;
    logic        ex_stall;
    logic        de_ready;
    logic [31:0] inst_code;
    logic [31:0] if_pc;

    rip_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_update   (pc_update),
        .pc_target   (pc_target),
        .ex_stall    (ex_stall),
        .de_ready    (de_ready),
        .inst_code   (inst_code),
        .if_pc       (if_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        q[$];
    logic [31:0] acc_log[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_due = 0;
    int          n_deliv  = 0;
    int          max_q    = 0;
    int          rdy_pct  = 100;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          track_q  = 1'b0;
    bit          mem_nop  = 1'b1;
    logic        c_rst, c_stall, c_upd;
    logic [31:0] c_tgt, exp_pc, stall_pc;
    logic        s_req, s_dr;
    logic [31:0] s_addr, s_pc, s_ic;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_nop) return NOP;
        return (a * 32'h9E37_79B1) ^ NOP;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample mid-cycle, model imem, advance.
    task automatic cycle();
        int lat;
        int due;
        @(negedge clk);
        rst       = c_rst;
        ex_stall  = c_stall;
        pc_update = c_upd;
        pc_target = c_tgt;
        imem_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
        if (!c_rst && q.size() > 0 && q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_dr   = de_ready;
        s_pc   = if_pc;
        s_ic   = inst_code;
        if (de_ready === 1'b1) begin
            check("deliver_pc", if_pc, exp_pc);
            check("deliver_inst", inst_code, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        if (imem_rvalid) void'(q.pop_front());
        if (imem_req === 1'b1 && imem_ready) begin
            lat = int'($urandom_range(lat_min, lat_max));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q.push_back('{addr: imem_addr, due: due});
            acc_log.push_back(imem_addr);
        end
        if (track_q && q.size() > max_q) max_q = q.size();
        if (c_upd) exp_pc = {c_tgt[31:2], 2'b00};
        if (c_rst) begin
            q.delete();
            exp_pc   = RESET_PC;
            last_due = 0;
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        int  start;
        bit  found;
        rst = 1'b1; ex_stall = 1'b0; pc_update = 1'b0; pc_target = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        c_rst = 1'b1; c_stall = 1'b0; c_upd = 1'b0; c_tgt = '0;
        exp_pc = RESET_PC;

        repeat (3) cycle();
        check("rst_req", s_req, 0);
        check("rst_de_ready", s_dr, 0);
        check("rst_inst", s_ic, NOP);
        check("rst_if_pc", s_pc, 0);

        // Reset release with a NOP-filled 1-cycle memory
        c_rst = 1'b0;
        cycle();
        check("c0_req", s_req, 1);
        check("c0_addr", s_addr, RESET_PC);
        check("c0_dr", s_dr, 0);
        cycle();
        check("c1_dr", s_dr, 0);
        cycle();
        check("c2_dr", s_dr, 1);
        check("c2_pc", s_pc, 32'h0);
        check("c2_inst", s_ic, NOP);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stream_dr", s_dr, 1);
        end

        c_rst = 1'b1;
        repeat (2) cycle();
        mem_nop = 1'b0;
        c_rst   = 1'b0;

        // Stall for 5 cycles mid-stream
        repeat (6) cycle();
        c_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("stall_dr", s_dr, 0);
            if (i >= 2) check("stall_req", s_req, 0);
        end
        stall_pc = exp_pc;
        c_stall  = 1'b0;
        cycle();
        check("resume_dr", s_dr, 1);
        check("resume_pc", s_pc, stall_pc);

        // Redirect to 0x103 with two requests outstanding
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (q.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        check("two_outstanding", found, 1);
        c_upd = 1'b1; c_tgt = 32'h0000_0103;
        cycle();
        check("redir_dr", s_dr, 0);
        check("redir_req", s_req, 0);
        c_upd = 1'b0;
        cycle();
        check("redir_addr", s_addr, 32'h0000_0100);
        check("redir_new_req", s_req, 1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_dr === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("redir_got", found, 1);
        check("redir_first_pc", s_pc, 32'h0000_0100);
        check("redir_first_inst", s_ic, 32'h3779_B113);

        // Sequential fetch across the top of the address space
        lat_min = 1; lat_max = 1;
        repeat (4) cycle();
        c_upd = 1'b1; c_tgt = 32'hFFFF_FFFC;
        cycle();
        c_upd = 1'b0;
        acc_log.delete();
        repeat (6) cycle();
        check("wrap_n", acc_log.size() >= 2, 1);
        if (acc_log.size() >= 2) begin
            check("wrap_a0", acc_log[0], 32'hFFFF_FFFC);
            check("wrap_a1", acc_log[1], 32'h0000_0000);
        end

        // Random ready, 1-3 cycle latency, occasional stall
        rdy_pct = 60; lat_min = 1; lat_max = 3;
        max_q = 0; track_q = 1'b1; start = n_deliv;
        for (int i = 0; i < 20000 && (n_deliv - start) < 1000; i++) begin
            c_stall = ($urandom_range(0, 99) < 15);
            cycle();
        end
        track_q = 1'b0; c_stall = 1'b0; rdy_pct = 100;
        check("rnd_delivered", (n_deliv - start) >= 1000, 1);
        check("rnd_outstanding_le_depth", max_q <= DEPTH, 1);

        // Reset pulse with a loaded buffer and one request outstanding
        c_rst = 1'b1;
        repeat (2) cycle();
        c_rst = 1'b0; lat_min = 2; lat_max = 2; c_stall = 1'b1;
        repeat (3) cycle();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 1) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        check("pre_rst_one_out", found, 1);
        c_rst = 1'b1;
        cycle();
        check("midrst_req", s_req, 0);
        check("midrst_dr", s_dr, 0);
        c_rst = 1'b0; c_stall = 1'b0;
        cycle();
        check("post_rst_addr", s_addr, RESET_PC);
        check("post_rst_req", s_req, 1);
        check("post_rst_dr", s_dr, 0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (s_dr === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check("post_rst_got", found, 1);
        check("post_rst_first_pc", s_pc, RESET_PC);
        repeat (10) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
